// File: rtl/decoder3_wb_pkg.sv
// rtl/decoder3_wb_pkg.sv - shared address map and helpers for the 1-to-3 Wishbone decoder
//
// Platform header for the uncore decoder. The SoC top and the linker-map
// generator both take the slave windows from here, so there is only one
// copy of the address map.
// Contents: default base/mask per slave, default timeout, slave index type,
// address-window match helper.
package decoder3_wb_pkg;

    localparam logic [31:0] S0_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] S0_MASK_DEF = 32'hF000_0000;
    localparam logic [31:0] S1_ADDR_DEF = 32'h1000_0000;
    localparam logic [31:0] S1_MASK_DEF = 32'hF000_0000;
    localparam logic [31:0] S2_ADDR_DEF = 32'h2000_0000;
    localparam logic [31:0] S2_MASK_DEF = 32'hF000_0000;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        SLV0 = 2'd0,
        SLV1 = 2'd1,
        SLV2 = 2'd2
    } slave_idx_t;

    // Operands are widened to 64 bits so one helper serves any address width.
    function automatic logic addr_match(input logic [63:0] adr,
                                        input logic [63:0] base,
                                        input logic [63:0] mask);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/decoder3_wb_if.sv
// rtl/decoder3_wb_if.sv - classic Wishbone bus bundle with master/slave views
//
// Signals: adr, wdat (master->slave data), rdat (slave->master data), we,
// sel, stb, cyc, ack, err.
// master modport: drives the request, receives rdat/ack. The slaves behind
//   this decoder are ack-only, so err is not part of the master view.
// slave modport : receives the request, drives rdat/ack/err.
interface decoder3_wb_if
    import decoder3_wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   wdat;
    logic [DATA_WIDTH-1:0]   rdat;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, wdat, we, sel, stb, cyc,
        input  rdat, ack
    );

    modport slave (
        input  adr, wdat, we, sel, stb, cyc,
        output rdat, ack, err
    );
endinterface

// File: rtl/decoder3_wb_timeout.sv
// rtl/decoder3_wb_timeout.sv - saturating wait counter with expiry flag
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (held while no access is outstanding)
//   enable    - count one waiting cycle
//   expired   - the current waiting cycle is the TIMEOUT_CYCLES-th one
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module decoder3_wb_timeout
    import decoder3_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    // The counter holds the number of waiting cycles already completed, so
    // it only needs to reach TIMEOUT_CYCLES-1; the cycle at that value is
    // the last one the slave gets.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/decoder3_wb.sv
// rtl/decoder3_wb.sv - registered 1-master to 3-slave Wishbone address decoder
//
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   wbm      - upstream bus (decoder is the slave): request in, rdat/ack/err out
//   wbs0..2  - downstream buses (decoder is the master): request out, rdat/ack in
// One access at a time. Unmapped addresses and slaves that do not ack within
// TIMEOUT_CYCLES end with a single-cycle err so the master never hangs.
module decoder3_wb
    import decoder3_wb_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] S0_ADDR        = ADDR_WIDTH'(S0_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] S0_MASK        = ADDR_WIDTH'(S0_MASK_DEF),
    parameter logic [ADDR_WIDTH-1:0] S1_ADDR        = ADDR_WIDTH'(S1_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] S1_MASK        = ADDR_WIDTH'(S1_MASK_DEF),
    parameter logic [ADDR_WIDTH-1:0] S2_ADDR        = ADDR_WIDTH'(S2_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] S2_MASK        = ADDR_WIDTH'(S2_MASK_DEF),
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    decoder3_wb_if.slave  wbm,
    decoder3_wb_if.master wbs0,
    decoder3_wb_if.master wbs1,
    decoder3_wb_if.master wbs2
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t     state;
    slave_idx_t sel_idx;

    logic hit0, hit1, hit2;
    logic active;
    logic ack_sel;
    logic expired;
    logic gate0, gate1, gate2;

    logic [ADDR_WIDTH-1:0]   adr_fwd;
    logic [DATA_WIDTH-1:0]   wdat_fwd;
    logic [SELECT_WIDTH-1:0] sel_fwd;
    logic [DATA_WIDTH-1:0]   rdat_sel;

    assign hit0 = addr_match(64'(wbm.adr), 64'(S0_ADDR), 64'(S0_MASK));
    assign hit1 = addr_match(64'(wbm.adr), 64'(S1_ADDR), 64'(S1_MASK));
    assign hit2 = addr_match(64'(wbm.adr), 64'(S2_ADDR), 64'(S2_MASK));

    assign active = (state == ST_ACTIVE);

    always_comb begin
        ack_sel  = 1'b0;
        rdat_sel = '0;
        case (sel_idx)
            SLV0: begin ack_sel = wbs0.ack; rdat_sel = wbs0.rdat; end
            SLV1: begin ack_sel = wbs1.ack; rdat_sel = wbs1.rdat; end
            SLV2: begin ack_sel = wbs2.ack; rdat_sel = wbs2.rdat; end
            default: begin ack_sel = 1'b0; rdat_sel = '0; end
        endcase
    end

    // Request fields go to every slave unmasked; only cyc/stb select one.
    assign adr_fwd  = wbm.adr;
    assign wdat_fwd = wbm.wdat;
    assign sel_fwd  = wbm.sel;

    assign wbs0.adr = adr_fwd;  assign wbs0.wdat = wdat_fwd;
    assign wbs0.sel = sel_fwd;  assign wbs0.we   = wbm.we;
    assign wbs1.adr = adr_fwd;  assign wbs1.wdat = wdat_fwd;
    assign wbs1.sel = sel_fwd;  assign wbs1.we   = wbm.we;
    assign wbs2.adr = adr_fwd;  assign wbs2.wdat = wdat_fwd;
    assign wbs2.sel = sel_fwd;  assign wbs2.we   = wbm.we;

    // Gating by the live wbm.cyc makes a master abort drop the slave cycle
    // in the same clock, before the state machine has caught up.
    assign gate0 = active && (sel_idx == SLV0) && wbm.cyc;
    assign gate1 = active && (sel_idx == SLV1) && wbm.cyc;
    assign gate2 = active && (sel_idx == SLV2) && wbm.cyc;

    assign wbs0.cyc = gate0;  assign wbs0.stb = gate0 && wbm.stb;
    assign wbs1.cyc = gate1;  assign wbs1.stb = gate1 && wbm.stb;
    assign wbs2.cyc = gate2;  assign wbs2.stb = gate2 && wbm.stb;

    assign wbm.ack  = active && ack_sel && wbm.cyc;
    assign wbm.rdat = active ? rdat_sel : '0;
    assign wbm.err  = (state == ST_ERR);

    decoder3_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!active),
        .enable (active && !ack_sel),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel_idx <= SLV0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wbm.cyc && wbm.stb) begin
                        // Overlapping windows resolve S0 > S1 > S2.
                        if (hit0) begin
                            sel_idx <= SLV0;
                            state   <= ST_ACTIVE;
                        end else if (hit1) begin
                            sel_idx <= SLV1;
                            state   <= ST_ACTIVE;
                        end else if (hit2) begin
                            sel_idx <= SLV2;
                            state   <= ST_ACTIVE;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Ack is tested before expiry so a last-moment ack wins.
                    if (!wbm.cyc || ack_sel) begin
                        state <= ST_IDLE;
                    end else if (expired) begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder3_wb.sv
// tb/tb_decoder3_wb.sv - self-checking bench for decoder3_wb
module tb_decoder3_wb;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder3_wb_if m ();
    decoder3_wb_if s0 ();
    decoder3_wb_if s1 ();
    decoder3_wb_if s2 ();

    assign s0.err = 1'b0;
    assign s1.err = 1'b0;
    assign s2.err = 1'b0;

    decoder3_wb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .wbm (m),
        .wbs0(s0),
        .wbs1(s1),
        .wbs2(s2)
    );

    int cyc_cnt = 0;
    int n_chk   = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Expected timeline of the current access, in absolute cycle numbers.
    int          e_tgt     = -1;
    int          e_start   = 0;
    int          e_cyc_end = -1;
    int          e_act_end = -1;
    int          e_resp    = -1;
    int          e_kind    = 0;   // 0 none, 1 ack, 2 err
    logic [31:0] e_rd      = 32'h0;

    int          mon_ack = -1;
    int          mon_err = -1;
    logic [31:0] mon_dat = 32'h0;
    logic [4:0]  mon_wesel = 5'h0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_cnt, act, exp);
    endtask

    function automatic int decode(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'h1:    return 1;
            4'h2:    return 2;
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin : cmp
        int c;
        bit in_cyc, in_act;
        logic [2:0] sc, ss;
        if (chk_en) begin
            c      = cyc_cnt;
            in_cyc = (c >= e_start) && (c <= e_cyc_end);
            in_act = (c >= e_start) && (c <= e_act_end);
            sc     = {s2.cyc, s1.cyc, s0.cyc};
            ss     = {s2.stb, s1.stb, s0.stb};
            for (int n = 0; n < 3; n++) begin
                chk("slave_cyc", 64'(sc[n]), 64'(in_cyc && (e_tgt == n)));
                chk("slave_stb", 64'(ss[n]), 64'(in_cyc && (e_tgt == n)));
            end
            chk("ack", 64'(m.ack), 64'((e_kind == 1) && (c == e_resp)));
            chk("err", 64'(m.err), 64'((e_kind == 2) && (c == e_resp)));
            if (in_cyc && (e_tgt >= 0)) chk("rdat", 64'(m.rdat), 64'(e_rd));
            else if (!in_act)           chk("rdat_idle", 64'(m.rdat), 64'd0);
            chk("fwd0", 64'({s0.we, s0.sel, s0.adr}), 64'({m.we, m.sel, m.adr}));
            chk("fwd1", 64'({s1.we, s1.sel, s1.adr}), 64'({m.we, m.sel, m.adr}));
            chk("fwd2", 64'({s2.we, s2.sel, s2.adr}), 64'({m.we, m.sel, m.adr}));
            chk("fwd0_dat", 64'(s0.wdat), 64'(m.wdat));
            chk("fwd1_dat", 64'(s1.wdat), 64'(m.wdat));
            chk("fwd2_dat", 64'(s2.wdat), 64'(m.wdat));
            if ((m.ack === 1'b1) && (mon_ack < 0)) begin
                mon_ack   = c;
                mon_dat   = m.rdat;
                mon_wesel = {s2.we, s2.sel};
            end
            if ((m.err === 1'b1) && (mon_err < 0)) mon_err = c;
        end
    end

    // kind: 0 normal, 1 master drops cyc at t+1+k, 2 rst pulsed at t+1+k.
    // w: waiting cycles before the target slave acks (>= 50 means never).
    task automatic do_access(input logic [31:0] a, input logic we, input logic [3:0] sel,
                             input logic [31:0] wd, input int w, input logic [31:0] rd,
                             input int kind, input int k, output int t);
        int tgt, m_drop, loop_end, late;
        step();
        t   = cyc_cnt;
        tgt = decode(a);
        mon_ack = -1;
        mon_err = -1;
        e_tgt   = tgt;
        e_start = t + 1;
        e_rd    = rd;
        if (tgt < 0) begin
            e_cyc_end = t;      e_act_end = t;      e_resp = t + 1;  e_kind = 2;
        end else if (kind == 1) begin
            e_cyc_end = t + k;  e_act_end = t + 1 + k; e_resp = -1;  e_kind = 0;
        end else if (kind == 2) begin
            e_cyc_end = t + 1 + k; e_act_end = t + 1 + k; e_resp = -1; e_kind = 0;
        end else if (w <= TO - 1) begin
            e_cyc_end = t + 1 + w; e_act_end = t + 1 + w; e_resp = t + 1 + w; e_kind = 1;
        end else begin
            e_cyc_end = t + TO; e_act_end = t + TO; e_resp = t + TO + 1; e_kind = 2;
        end
        m_drop   = (kind == 1) ? t + 1 + k : (kind == 2) ? t + 2 + k : e_resp + 1;
        late     = ((tgt >= 0) && (w < 50)) ? t + 1 + w : 0;
        loop_end = (late > m_drop) ? late : m_drop;
        m.adr  = a;
        m.wdat = wd;
        m.we   = we;
        m.sel  = sel;
        s0.rdat = (tgt == 0) ? rd : 32'hBAD0_0000;
        s1.rdat = (tgt == 1) ? rd : 32'hBAD0_0001;
        s2.rdat = (tgt == 2) ? rd : 32'hBAD0_0002;
        for (int c = t; c <= loop_end; c++) begin
            if (c != t) step();
            m.cyc  = (c < m_drop);
            m.stb  = (c < m_drop);
            rst    = (kind == 2) && (c == t + 1 + k);
            // Besides the real ack, a stray ack from the next slave round
            // the ring lands on the first active cycle of waiting accesses.
            s0.ack = ((tgt == 0) && (c == late)) || ((tgt == 2) && (w > 0) && (c == t + 1));
            s1.ack = ((tgt == 1) && (c == late)) || ((tgt == 0) && (w > 0) && (c == t + 1));
            s2.ack = ((tgt == 2) && (c == late)) || ((tgt == 1) && (w > 0) && (c == t + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        m.cyc = 0; m.stb = 0; m.adr = 0; m.wdat = 0; m.we = 0; m.sel = 0;
        s0.ack = 0; s1.ack = 0; s2.ack = 0;
        s0.rdat = 0; s1.rdat = 0; s2.rdat = 0;

        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Ack from a slave while idle must not reach the master.
        step(); s1.ack = 1'b1;
        step(); s1.ack = 1'b0;

        do_access(32'h1000_0040, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 0, 0, t);
        chk("s1_read_latency", 64'(mon_ack - t), 64'd1);
        chk("s1_read_data", 64'(mon_dat), 64'hCAFE_F00D);
        chk("s1_read_no_err", 64'(mon_err < 0), 64'd1);

        do_access(32'h2000_0004, 1'b1, 4'b0011, 32'h1234_5678, 3, 32'h0, 0, 0, t);
        chk("s2_write_latency", 64'(mon_ack - t), 64'd4);
        chk("s2_write_we_sel", 64'(mon_wesel), 64'h13);
        chk("s2_write_no_err", 64'(mon_err < 0), 64'd1);

        do_access(32'h7000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, 0, 0, t);
        chk("unmapped_err_latency", 64'(mon_err - t), 64'd1);
        chk("unmapped_no_ack", 64'(mon_ack < 0), 64'd1);

        do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 100, 32'h0, 0, 0, t);
        chk("timeout_err_latency", 64'(mon_err - t), 64'd9);
        chk("timeout_no_ack", 64'(mon_ack < 0), 64'd1);

        do_access(32'h1000_0008, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_BEEF, 0, 0, t);
        chk("after_timeout_latency", 64'(mon_ack - t), 64'd2);
        chk("after_timeout_data", 64'(mon_dat), 64'h0BAD_BEEF);

        do_access(32'h0000_0200, 1'b0, 4'hF, 32'h0, 7, 32'h5555_AAAA, 0, 0, t);
        chk("expiry_ack_latency", 64'(mon_ack - t), 64'd8);
        chk("expiry_no_err", 64'(mon_err < 0), 64'd1);

        do_access(32'h1000_0010, 1'b0, 4'hF, 32'h0, 100, 32'h0, 2, 1, t);
        chk("reset_mid_no_ack", 64'(mon_ack < 0), 64'd1);
        chk("reset_mid_no_err", 64'(mon_err < 0), 64'd1);

        do_access(32'h2000_0020, 1'b1, 4'hF, 32'hDEAD_0001, 4, 32'h0, 1, 2, t);
        chk("abort_late_ack_dropped", 64'(mon_ack < 0), 64'd1);
        chk("abort_no_err", 64'(mon_err < 0), 64'd1);

        do_access(32'h0000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0102_0304, 0, 0, t);
        chk("final_s0_latency", 64'(mon_ack - t), 64'd1);
        chk("final_s0_data", 64'(mon_dat), 64'h0102_0304);

        step();
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
